idli_sqi_sram: RTL and testbench



---
 rtl/idli_sqi_sram.sv | 193 +++++++++++++++++++
 tb/tb_idli_sqi_sram.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_sram.sv
// Quad-SPI (SQI) SRAM responder for the idli core's external memory port.
// Decodes read (0x03) and write (0x02) commands, takes a 16-bit address
// (low ADDR_W bits used), auto-increments the byte pointer and transfers
// one nibble per clk cycle while cs_n is low.
//
// Ports:
//   clk      system clock, also the SQI bit clock
//   rst_n    synchronous active-low reset
//   cs_n     chip select from host, active-low
//   sio_in   SQI nibble from host
//   sio_out  SQI nibble to host (registered)
//   sio_oe   drive enable for sio_out, all bits equal
//   cmd_err  sticky flag, set by an unsupported command byte
//
// Assumes ADDR_W >= 5 and DUMMY_NIB >= 1.
module idli_sqi_sram #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DUMMY_NIB = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       cmd_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRead,
        StWrite,
        StIgnore
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        cmd_hi_q, cmd_hi_d;
    logic              is_wr_q, is_wr_d;
    // Read: next nibble to emit is the low one. Write: high nibble is held.
    logic              half_q, half_d;
    logic [3:0]        hold_q, hold_d;
    logic [3:0]        sio_out_q, sio_out_d;
    logic              cmd_err_q, cmd_err_d;

    logic [7:0] mem [Depth];
    logic [7:0] mem_rd;
    logic       mem_we;

    logic [7:0] cmd_byte;
    logic       cmd_ok;
    logic       addr_last;
    logic       dummy_last;

    assign cmd_byte   = {cmd_hi_q, sio_in};
    assign cmd_ok     = (cmd_byte == 8'h03) || (cmd_byte == 8'h02);
    assign addr_last  = (cnt_q == 8'd3);
    assign dummy_last = (cnt_q == 8'(DUMMY_NIB - 1));
    assign mem_rd     = mem[ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cs_n high always returns to idle.
    always_comb begin
        state_d = state_q;
        if (cs_n) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StCmd;
                StCmd:    state_d = cmd_ok ? StAddr : StIgnore;
                StAddr:   if (addr_last) state_d = is_wr_q ? StWrite : StDummy;
                StDummy:  if (dummy_last) state_d = StRead;
                StRead:   state_d = StRead;
                StWrite:  state_d = StWrite;
                StIgnore: state_d = StIgnore;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        sio_oe  = (state_q == StRead) ? 4'hF : 4'h0;
        sio_out = sio_out_q;
        cmd_err = cmd_err_q;
    end

    // Datapath next-state
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = '0;
        cmd_hi_d  = cmd_hi_q;
        is_wr_d   = is_wr_q;
        half_d    = half_q;
        hold_d    = hold_q;
        sio_out_d = sio_out_q;
        cmd_err_d = cmd_err_q;
        mem_we    = 1'b0;
        if (!cs_n) begin
            unique case (state_q)
                StIdle: begin
                    cmd_hi_d = sio_in;
                    half_d   = 1'b0;
                end
                StCmd: begin
                    is_wr_d = (sio_in == 4'h2);
                    if (!cmd_ok) cmd_err_d = 1'b1;
                end
                StAddr: begin
                    // Shifting nibbles in keeps only the low ADDR_W address bits.
                    ptr_d  = {ptr_q[ADDR_W-5:0], sio_in};
                    cnt_d  = addr_last ? 8'd0 : cnt_q + 8'd1;
                    half_d = 1'b0;
                end
                StDummy: begin
                    cnt_d = cnt_q + 8'd1;
                    if (dummy_last) begin
                        sio_out_d = mem_rd[7:4];
                        half_d    = 1'b1;
                    end
                end
                StRead: begin
                    if (half_q) begin
                        sio_out_d = mem_rd[3:0];
                        ptr_d     = ptr_q + ADDR_W'(1);
                        half_d    = 1'b0;
                    end else begin
                        sio_out_d = mem_rd[7:4];
                        half_d    = 1'b1;
                    end
                end
                StWrite: begin
                    if (half_q) begin
                        // Reset on the same edge must not commit a write.
                        mem_we = rst_n;
                        ptr_d  = ptr_q + ADDR_W'(1);
                        half_d = 1'b0;
                    end else begin
                        hold_d = sio_in;
                        half_d = 1'b1;
                    end
                end
                StIgnore: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            cmd_hi_q  <= '0;
            is_wr_q   <= 1'b0;
            half_q    <= 1'b0;
            hold_q    <= '0;
            sio_out_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cmd_hi_q  <= cmd_hi_d;
            is_wr_q   <= is_wr_d;
            half_q    <= half_d;
            hold_q    <= hold_d;
            sio_out_q <= sio_out_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Array is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= {hold_q, sio_in};
        end
    end

endmodule

// File: tb/tb_idli_sqi_sram.sv
module tb_idli_sqi_sram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;
    logic       cmd_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    idli_sqi_sram #(
        .ADDR_W   (9),
        .DUMMY_NIB(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_n   (cs_n),
        .sio_in (sio_in),
        .sio_out(sio_out),
        .sio_oe (sio_oe),
        .cmd_err(cmd_err)
    );

    // Drive one beat, then look at outputs 1 time unit after the edge.
    task automatic step(input logic cs, input logic [3:0] nib);
        cs_n   = cs;
        sio_in = nib;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [15:0] addr);
        step(1'b0, cmd[7:4]);
        step(1'b0, cmd[3:0]);
        step(1'b0, addr[15:12]);
        step(1'b0, addr[11:8]);
        step(1'b0, addr[7:4]);
        step(1'b0, addr[3:0]);
    endtask

    task automatic read_hdr(input logic [15:0] addr);
        hdr(8'h03, addr);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
    endtask

    // High nibble is already on the bus when this is entered.
    task automatic read_expect(input string tag, input logic [7:0] exp);
        chk({tag, "_oe"}, {4'h0, sio_oe}, 8'h0F);
        chk({tag, "_hi"}, {4'h0, sio_out}, {4'h0, exp[7:4]});
        step(1'b0, 4'h0);
        chk({tag, "_lo"}, {4'h0, sio_out}, {4'h0, exp[3:0]});
        step(1'b0, 4'h0);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        step(1'b0, b[7:4]);
        step(1'b0, b[3:0]);
    endtask

    initial begin
        // Reset
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        chk("rst_oe", {4'h0, sio_oe}, 8'h00);
        chk("rst_out", {4'h0, sio_out}, 8'h00);
        chk("rst_err", {7'h0, cmd_err}, 8'h00);
        rst_n = 1'b1;
        step(1'b1, 4'h0);

        // Write A5,3C at 0x0010 then read back
        hdr(8'h02, 16'h0010);
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        chk("wr_oe", {4'h0, sio_oe}, 8'h00);
        step(1'b1, 4'h0);
        chk("mem010", dut.mem[9'h010], 8'hA5);
        chk("mem011", dut.mem[9'h011], 8'h3C);
        read_hdr(16'h0010);
        read_expect("rd0", 8'hA5);
        read_expect("rd1", 8'h3C);
        step(1'b1, 4'h0);
        chk("rd_end_oe", {4'h0, sio_oe}, 8'h00);

        // Pointer wrap on write and read
        hdr(8'h02, 16'h01FF);
        wr_byte(8'h11);
        wr_byte(8'h22);
        step(1'b1, 4'h0);
        chk("wrap1ff", dut.mem[9'h1FF], 8'h11);
        chk("wrap000", dut.mem[9'h000], 8'h22);
        read_hdr(16'hFFFF);
        read_expect("wrap_rd0", 8'h11);
        read_expect("wrap_rd1", 8'h22);
        step(1'b1, 4'h0);

        // Unsupported command 0x9F, followed by a would-be write payload
        step(1'b0, 4'h9);
        step(1'b0, 4'hF);
        chk("bad_err", {7'h0, cmd_err}, 8'h01);
        chk("bad_oe_cmd", {4'h0, sio_oe}, 8'h00);
        step(1'b0, 4'h0);
        step(1'b0, 4'h2);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h1);
        step(1'b0, 4'h0);
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        chk("bad_oe", {4'h0, sio_oe}, 8'h00);
        step(1'b1, 4'h0);
        chk("bad_mem010", dut.mem[9'h010], 8'hA5);
        read_hdr(16'h0010);
        read_expect("bad_rd", 8'hA5);
        chk("bad_err_sticky", {7'h0, cmd_err}, 8'h01);
        step(1'b1, 4'h0);

        // Partial write: preload 0x020/0x021, then 7,E,4
        hdr(8'h02, 16'h0020);
        wr_byte(8'h00);
        wr_byte(8'h55);
        step(1'b1, 4'h0);
        hdr(8'h02, 16'h0020);
        wr_byte(8'h7E);
        step(1'b0, 4'h4);
        step(1'b1, 4'h0);
        chk("part020", dut.mem[9'h020], 8'h7E);
        chk("part021", dut.mem[9'h021], 8'h55);

        // Reset at read beat 9, then decode a fresh command from beat 0
        read_hdr(16'h0010);
        chk("abort_b8_hi", {4'h0, sio_out}, 8'h0A);
        step(1'b0, 4'h0);
        chk("abort_b9_lo", {4'h0, sio_out}, 8'h05);
        rst_n = 1'b0;
        step(1'b0, 4'h0);
        chk("abort_oe", {4'h0, sio_oe}, 8'h00);
        chk("abort_err", {7'h0, cmd_err}, 8'h00);
        chk("abort_out", {4'h0, sio_out}, 8'h00);
        rst_n = 1'b1;
        read_hdr(16'h0011);
        read_expect("abort_rd", 8'h3C);
        step(1'b1, 4'h0);

        // One-cycle cs_n glitch between two reads
        read_hdr(16'h0010);
        read_expect("gl_rd0", 8'hA5);
        step(1'b1, 4'h0);
        chk("gl_oe", {4'h0, sio_oe}, 8'h00);
        read_hdr(16'h0011);
        read_expect("gl_rd1", 8'h3C);
        step(1'b1, 4'h0);
        chk("gl_err", {7'h0, cmd_err}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
